// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with hold limit driving a registered 4:1 data mux
// Grants one of four requesters at a time, bounds each grant to MAX_HOLD cycles.
module mux_rr_arbiter #(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_c,
   input  logic [DATA_W-1:0] in_d,
   output logic [3:0]        gnt,
   output logic [1:0]        s,
   output logic [DATA_W-1:0] out_a,
   output logic              valid
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        last;
   logic [1:0]        last_nxt;
   logic [1:0]        s_nxt;
   logic [3:0]        gnt_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic [1:0]        win;
   logic [1:0]        idx;
   logic              win_found;
   logic              keep;
   logic [DATA_W-1:0] sel_data;

   // Rotating search starting after the last winner; the last winner itself is tried last.
   always_comb begin
      win       = 2'd0;
      win_found = 1'b0;
      idx       = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win       = idx;
         end
      end
   end

   assign keep = (state == GRANT) && req[s] && (hold_cnt != HOLD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = GRANT;
         GRANT:   if (!keep && !win_found) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt  = gnt;
      s_nxt    = s;
      last_nxt = last;
      hold_nxt = hold_cnt;
      if (keep) begin
         hold_nxt = hold_cnt + HOLD_W'(1);
      end else if (win_found) begin
         gnt_nxt  = 4'b0001 << win;
         s_nxt    = win;
         last_nxt = win;
         hold_nxt = '0;
      end else begin
         gnt_nxt  = 4'b0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt      <= 4'b0000;
         s        <= 2'd0;
         last     <= 2'd3;
         hold_cnt <= '0;
      end else begin
         gnt      <= gnt_nxt;
         s        <= s_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      case (s)
         2'd0:    sel_data = in_a;
         2'd1:    sel_data = in_b;
         2'd2:    sel_data = in_c;
         default: sel_data = in_d;
      endcase
   end

   // Data lags the grant by one cycle and holds while nothing is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_a <= '0;
         valid <= 1'b0;
      end else begin
         valid <= (state == GRANT);
         if (state == GRANT) begin
            out_a <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
// Directed scenarios then random traffic, all compared against a behavioural model.
module tb_mux_rr_arbiter;

   localparam int DW       = 4;
   localparam int MAX_HOLD = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [DW-1:0] in_a, in_b, in_c, in_d;
   logic [3:0]    gnt;
   logic [1:0]    s;
   logic [DW-1:0] out_a;
   logic          valid;

   int checks   = 0;
   int failures = 0;

   int            m_owner, m_last, m_s, m_hold;
   logic [DW-1:0] m_out;
   logic          m_valid;
   int            wait_c [4];
   int            max_wait;

   mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
      .gnt(gnt), .s(s), .out_a(out_a), .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int search(input int from, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int j;
         j = (from + k) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_last = 3; m_s = 0; m_hold = 0;
      m_out = '0; m_valid = 1'b0;
   endtask

   task automatic model_edge();
      logic [DW-1:0] d [4];
      int w;
      d[0] = in_a; d[1] = in_b; d[2] = in_c; d[3] = in_d;
      m_valid = (m_owner >= 0);
      if (m_owner >= 0) m_out = d[m_s];
      if (m_owner >= 0 && req[m_owner] && m_hold < MAX_HOLD - 1) begin
         m_hold++;
      end else begin
         w = search(m_last, req);
         if (w >= 0) begin
            m_owner = w; m_s = w; m_last = w; m_hold = 0;
         end else begin
            m_owner = -1;
         end
      end
   endtask

   task automatic compare();
      logic [3:0] eg;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check("gnt", 32'(gnt), 32'(eg));
      check("s", 32'(s), 32'(m_s));
      check("out_a", 32'(out_a), 32'(m_out));
      check("valid", 32'(valid), 32'(m_valid));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
      for (int i = 0; i < 4; i++) begin
         if (req[i] && !gnt[i]) wait_c[i]++;
         else wait_c[i] = 0;
         if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      in_a = DW'($urandom); in_b = DW'($urandom);
      in_c = DW'($urandom); in_d = DW'($urandom);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 4'hF;
      in_a = '0; in_b = '0; in_c = '0; in_d = '0;
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
      max_wait = 0;
      model_reset();
      #2;
      compare();
      @(posedge clk);
      #1;
      compare();
      rst = 1'b0;
      step();
      check("first_gnt", 32'(gnt), 32'h1);

      // Rotation under full request load
      steps(41);

      // Single requester c, re-granted seamlessly at timeout
      pulse_reset();
      req = 4'b0100;
      steps(20);

      // Idle gap then new request searched from a+1
      req = 4'b0001;
      steps(3);
      req = 4'b0000;
      steps(3);
      req = 4'b0100;
      steps(3);

      // Early release of b hands over to d with no gap
      pulse_reset();
      req = 4'b0010;
      step();
      req = 4'b1010;
      steps(2);
      req = 4'b1000;
      steps(3);
      check("handover_s", 32'(s), 32'd3);

      // Async reset while d is granted, then a/d both request
      pulse_reset();
      check("async_gnt", 32'(gnt), 32'h0);
      req = 4'b1001;
      step();
      check("after_rst_gnt", 32'(gnt), 32'h1);

      // Random traffic with sticky requests
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
      max_wait = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(5) == 0) req[i] = ~req[i];
         end
         step();
      end
      check("max_wait_bound", 32'(max_wait <= 3 * MAX_HOLD + 1), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
